// File: rtl/mul_share_sched_if.sv
// Bundle between two multiply requesters, the shared scheduler and the
// external multiplier. The master side is the requester/multiplier environment.
interface mul_share_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_out;
  logic        rsp0_valid;
  logic [31:0] rsp0_data;
  logic        rsp1_valid;
  logic [31:0] rsp1_data;
  logic        busy;
  logic        last_grant;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output mul_out,
    input  req0_ready, req1_ready,
    input  mul_a, mul_b,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    input  busy, last_grant
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  mul_out,
    output req0_ready, req1_ready,
    output mul_a, mul_b,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    output busy, last_grant
  );
endinterface

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one 16x16 multiplier between two requesters;
// an ID token pipeline routes each product back to the port that issued it.
module mul_share_sched #(
  parameter int MUL_LAT   = 2,
  parameter bit PIPELINED = 1'b1
) (
  input logic              clk,
  input logic              reset,
  mul_share_sched_if.slave bus
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t               state;
  logic                 lg_q;
  logic                 can_issue;
  logic                 grant0;
  logic                 grant1;
  logic                 issue;
  logic [15:0]          op_a_p0;
  logic [15:0]          op_b_p0;
  logic [MUL_LAT-1:0]   tok_vld_p;
  logic [MUL_LAT-1:0]   tok_id_p;
  logic                 ret_vld;
  logic                 ret_id;
  logic                 rsp0_vld_p1;
  logic                 rsp1_vld_p1;
  logic [31:0]          rsp0_data_p1;
  logic [31:0]          rsp1_data_p1;

  // A port wins when it alone is asking, or when the other port won last time.
  function automatic logic wins(input logic mine, input logic other,
                                input logic other_won_last);
    return mine & (~other | other_won_last);
  endfunction

  always_comb begin
    can_issue = PIPELINED ? 1'b1 : (state == S_IDLE);
    grant0    = can_issue & wins(bus.req0_valid, bus.req1_valid, lg_q);
    grant1    = can_issue & wins(bus.req1_valid, bus.req0_valid, ~lg_q);
    issue     = grant0 | grant1;
  end

  assign ret_vld = tok_vld_p[MUL_LAT-1];
  assign ret_id  = tok_id_p[MUL_LAT-1];

  // Stage p0: operand registers feeding the multiplier
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a_p0 <= '0;
      op_b_p0 <= '0;
      lg_q    <= 1'b1;
    end else if (issue) begin
      op_a_p0 <= grant1 ? bus.req1_a : bus.req0_a;
      op_b_p0 <= grant1 ? bus.req1_b : bus.req0_b;
      lg_q    <= grant1;
    end
  end

  // Token pipeline, aligned with the multiplier latency
  always_ff @(posedge clk) begin
    if (reset) begin
      tok_vld_p <= '0;
      tok_id_p  <= '0;
    end else begin
      tok_vld_p[0] <= issue;
      tok_id_p[0]  <= grant1;
      for (int i = 1; i < MUL_LAT; i++) begin
        tok_vld_p[i] <= tok_vld_p[i-1];
        tok_id_p[i]  <= tok_id_p[i-1];
      end
    end
  end

  // Stage p1: capture the product for the port named by the retiring token
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp0_vld_p1  <= 1'b0;
      rsp1_vld_p1  <= 1'b0;
      rsp0_data_p1 <= '0;
      rsp1_data_p1 <= '0;
    end else begin
      rsp0_vld_p1 <= ret_vld & ~ret_id;
      rsp1_vld_p1 <= ret_vld & ret_id;
      if (ret_vld && !ret_id) rsp0_data_p1 <= bus.mul_out;
      if (ret_vld && ret_id)  rsp1_data_p1 <= bus.mul_out;
    end
  end

  // Non-pipelined mode: stay in WAIT through the response cycle so the next
  // issue lands one cycle after the pulse is visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (issue && !PIPELINED) state <= S_WAIT;
        S_WAIT: if (rsp0_vld_p1 || rsp1_vld_p1) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.mul_a      = op_a_p0;
  assign bus.mul_b      = op_b_p0;
  assign bus.rsp0_valid = rsp0_vld_p1;
  assign bus.rsp0_data  = rsp0_data_p1;
  assign bus.rsp1_valid = rsp1_vld_p1;
  assign bus.rsp1_data  = rsp1_data_p1;
  assign bus.busy       = |tok_vld_p;
  assign bus.last_grant = lg_q;

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed bench: a pipelined and a non-pipelined scheduler, each driving a
// two-cycle exact multiplier model (operands registered, product one cycle later).
module tb_mul_share_sched;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mul_share_sched_if pif ();
  mul_share_sched_if sif ();

  mul_share_sched #(.MUL_LAT(2), .PIPELINED(1'b1)) dut_p (
    .clk(clk), .reset(reset), .bus(pif)
  );
  mul_share_sched #(.MUL_LAT(2), .PIPELINED(1'b0)) dut_s (
    .clk(clk), .reset(reset), .bus(sif)
  );

  logic [31:0] prod_p;
  logic [31:0] prod_s;
  always_ff @(posedge clk) begin
    prod_p <= {16'd0, pif.mul_a} * {16'd0, pif.mul_b};
    prod_s <= {16'd0, sif.mul_a} * {16'd0, sif.mul_b};
  end
  assign pif.mul_out = prod_p;
  assign sif.mul_out = prod_s;

  typedef struct {
    logic        r0v;
    logic [15:0] r0a;
    logic [15:0] r0b;
    logic        r1v;
    logic [15:0] r1a;
    logic [15:0] r1b;
    logic        rdy0;
    logic        rdy1;
    logic        s0v;
    logic [31:0] s0d;
    logic        s1v;
    logic [31:0] s1d;
    logic        busy;
    logic        lg;
    logic [15:0] ma;
    logic [15:0] mb;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(
    input logic r0v, input logic [15:0] r0a, input logic [15:0] r0b,
    input logic r1v, input logic [15:0] r1a, input logic [15:0] r1b,
    input logic rdy0, input logic rdy1,
    input logic s0v, input logic [31:0] s0d,
    input logic s1v, input logic [31:0] s1d,
    input logic busy, input logic lg,
    input logic [15:0] ma, input logic [15:0] mb);
    vec_t v;
    v.r0v = r0v; v.r0a = r0a; v.r0b = r0b;
    v.r1v = r1v; v.r1a = r1a; v.r1b = r1b;
    v.rdy0 = rdy0; v.rdy1 = rdy1;
    v.s0v = s0v; v.s0d = s0d; v.s1v = s1v; v.s1d = s1d;
    v.busy = busy; v.lg = lg; v.ma = ma; v.mb = mb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    pif.req0_valid = 1'b0; pif.req0_a = '0; pif.req0_b = '0;
    pif.req1_valid = 1'b0; pif.req1_a = '0; pif.req1_b = '0;
    sif.req0_valid = 1'b0; sif.req0_a = '0; sif.req0_b = '0;
    sif.req1_valid = 1'b0; sif.req1_a = '0; sif.req1_b = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    bit found;
    int lat;

    // r0v r0a r0b  r1v r1a r1b  rdy0 rdy1  s0v s0d  s1v s1d  busy lg  ma mb
    vt[0]  = mk(0, 0, 0,  0, 0, 0,              0, 0, 0, 0,  0, 0,            0, 1, 0, 0);
    vt[1]  = mk(1, 3, 5,  0, 0, 0,              1, 0, 0, 0,  0, 0,            0, 1, 0, 0);
    vt[2]  = mk(0, 0, 0,  0, 0, 0,              0, 0, 0, 0,  0, 0,            1, 0, 3, 5);
    vt[3]  = mk(0, 0, 0,  0, 0, 0,              0, 0, 0, 0,  0, 0,            1, 0, 3, 5);
    vt[4]  = mk(0, 0, 0,  0, 0, 0,              0, 0, 1, 15, 0, 0,            0, 0, 3, 5);
    vt[5]  = mk(0, 0, 0,  0, 0, 0,              0, 0, 0, 15, 0, 0,            0, 0, 3, 5);
    vt[6]  = mk(0, 0, 0,  1, 16'hFFFF, 16'hFFFF, 0, 1, 0, 15, 0, 0,           0, 0, 3, 5);
    vt[7]  = mk(1, 7, 9,  1, 100, 200,          1, 0, 0, 15, 0, 0,            1, 1, 16'hFFFF, 16'hFFFF);
    vt[8]  = mk(1, 7, 9,  1, 100, 200,          0, 1, 0, 15, 0, 0,            1, 0, 7, 9);
    vt[9]  = mk(1, 7, 9,  1, 100, 200,          1, 0, 0, 15, 1, 32'hFFFE0001, 1, 1, 100, 200);
    vt[10] = mk(1, 7, 9,  1, 100, 200,          0, 1, 1, 63, 0, 32'hFFFE0001, 1, 0, 7, 9);
    vt[11] = mk(0, 0, 0,  0, 0, 0,              0, 0, 0, 63, 1, 20000,        1, 1, 100, 200);
    vt[12] = mk(0, 0, 0,  0, 0, 0,              0, 0, 1, 63, 0, 20000,        1, 1, 100, 200);
    vt[13] = mk(0, 0, 0,  0, 0, 0,              0, 0, 0, 63, 1, 20000,        0, 1, 100, 200);
    vt[14] = mk(0, 0, 0,  0, 0, 0,              0, 0, 0, 63, 0, 20000,        0, 1, 100, 200);

    idle_all();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mul_a", {16'd0, pif.mul_a}, 0);
    chk("rst_mul_b", {16'd0, pif.mul_b}, 0);
    chk("rst_rsp0_valid", {31'd0, pif.rsp0_valid}, 0);
    chk("rst_rsp1_valid", {31'd0, pif.rsp1_valid}, 0);
    chk("rst_rsp0_data", pif.rsp0_data, 0);
    chk("rst_rsp1_data", pif.rsp1_data, 0);
    chk("rst_busy", {31'd0, pif.busy}, 0);
    chk("rst_last_grant", {31'd0, pif.last_grant}, 1);
    chk("rst_s_last_grant", {31'd0, sif.last_grant}, 1);
    chk("rst_s_busy", {31'd0, sif.busy}, 0);

    // Ready follows the valids alone right after reset (no edge is crossed).
    pif.req1_valid = 1'b1; #1;
    chk("rst_only1_rdy0", {31'd0, pif.req0_ready}, 0);
    chk("rst_only1_rdy1", {31'd0, pif.req1_ready}, 1);
    pif.req0_valid = 1'b1; #1;
    chk("rst_both_rdy0", {31'd0, pif.req0_ready}, 1);
    chk("rst_both_rdy1", {31'd0, pif.req1_ready}, 0);
    pif.req1_valid = 1'b0; #1;
    chk("rst_only0_rdy0", {31'd0, pif.req0_ready}, 1);
    chk("rst_only0_rdy1", {31'd0, pif.req1_ready}, 0);
    pif.req0_valid = 1'b0; #1;
    chk("rst_none_rdy0", {31'd0, pif.req0_ready}, 0);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      pif.req0_valid = vt[i].r0v; pif.req0_a = vt[i].r0a; pif.req0_b = vt[i].r0b;
      pif.req1_valid = vt[i].r1v; pif.req1_a = vt[i].r1a; pif.req1_b = vt[i].r1b;
      #1;
      chk($sformatf("row%0d_ready0", i), {31'd0, pif.req0_ready}, {31'd0, vt[i].rdy0});
      chk($sformatf("row%0d_ready1", i), {31'd0, pif.req1_ready}, {31'd0, vt[i].rdy1});
      chk($sformatf("row%0d_rsp0_valid", i), {31'd0, pif.rsp0_valid}, {31'd0, vt[i].s0v});
      chk($sformatf("row%0d_rsp0_data", i), pif.rsp0_data, vt[i].s0d);
      chk($sformatf("row%0d_rsp1_valid", i), {31'd0, pif.rsp1_valid}, {31'd0, vt[i].s1v});
      chk($sformatf("row%0d_rsp1_data", i), pif.rsp1_data, vt[i].s1d);
      chk($sformatf("row%0d_busy", i), {31'd0, pif.busy}, {31'd0, vt[i].busy});
      chk($sformatf("row%0d_last_grant", i), {31'd0, pif.last_grant}, {31'd0, vt[i].lg});
      chk($sformatf("row%0d_mul_a", i), {16'd0, pif.mul_a}, {16'd0, vt[i].ma});
      chk($sformatf("row%0d_mul_b", i), {16'd0, pif.mul_b}, {16'd0, vt[i].mb});
    end
    @(negedge clk);
    idle_all();

    // Non-pipelined: both ports valid continuously, four-cycle grant period.
    for (int c = 0; c < 12; c++) begin
      int phase;
      int port;
      @(negedge clk);
      if (c == 0) begin
        sif.req0_valid = 1'b1; sif.req0_a = 16'd7;   sif.req0_b = 16'd9;
        sif.req1_valid = 1'b1; sif.req1_a = 16'd100; sif.req1_b = 16'd200;
      end
      #1;
      phase = c % 4;
      port  = (c / 4) % 2;
      chk($sformatf("ser%0d_ready0", c), {31'd0, sif.req0_ready}, (phase == 0 && port == 0) ? 1 : 0);
      chk($sformatf("ser%0d_ready1", c), {31'd0, sif.req1_ready}, (phase == 0 && port == 1) ? 1 : 0);
      chk($sformatf("ser%0d_busy", c), {31'd0, sif.busy}, (phase == 1 || phase == 2) ? 1 : 0);
      chk($sformatf("ser%0d_rsp0_valid", c), {31'd0, sif.rsp0_valid}, (phase == 3 && port == 0) ? 1 : 0);
      chk($sformatf("ser%0d_rsp1_valid", c), {31'd0, sif.rsp1_valid}, (phase == 3 && port == 1) ? 1 : 0);
      if (phase == 3 && port == 0) chk($sformatf("ser%0d_rsp0_data", c), sif.rsp0_data, 63);
      if (phase == 3 && port == 1) chk($sformatf("ser%0d_rsp1_data", c), sif.rsp1_data, 20000);
    end
    @(negedge clk);
    idle_all();

    // Reset while an op is in flight on the pipelined scheduler.
    @(negedge clk);
    pif.req0_valid = 1'b1; pif.req0_a = 16'd3; pif.req0_b = 16'd5;
    #1;
    chk("mid_issue_ready0", {31'd0, pif.req0_ready}, 1);
    @(negedge clk);
    pif.req0_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_busy_in_flight", {31'd0, pif.busy}, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_busy_after_reset", {31'd0, pif.busy}, 0);
    chk("mid_mul_a_after_reset", {16'd0, pif.mul_a}, 0);
    chk("mid_rsp0_data_after_reset", pif.rsp0_data, 0);
    chk("mid_last_grant_after_reset", {31'd0, pif.last_grant}, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      chk($sformatf("mid_no_rsp0_%0d", k), {31'd0, pif.rsp0_valid}, 0);
    end

    @(negedge clk);
    pif.req0_valid = 1'b1; pif.req0_a = 16'd11; pif.req0_b = 16'd13;
    #1;
    chk("post_reset_ready0", {31'd0, pif.req0_ready}, 1);
    found = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8 && !found; k++) begin
      @(negedge clk);
      if (k == 1) pif.req0_valid = 1'b0;
      #1;
      if (pif.rsp0_valid) begin
        found = 1'b1;
        lat = k;
        chk("post_reset_rsp0_data", pif.rsp0_data, 143);
      end
    end
    chk("post_reset_rsp0_seen", {31'd0, found}, 1);
    chk("post_reset_rsp0_latency", lat, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
